// File: rtl/pwm_bank_pkg.sv
// Shared constants for the multi-channel PWM peripheral: register offsets,
// CTRL bit positions, mode encoding and the center-mode count direction.
package pwm_bank_pkg;

    localparam int OFF_CTRL     = 'h00;
    localparam int OFF_PRESCALE = 'h04;
    localparam int OFF_PERIOD   = 'h08;
    localparam int OFF_DUTY     = 'h0C;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_PFLAG_BIT = 8;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int duty_off(input int ch);
        return OFF_DUTY + 4 * ch;
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Peripheral bus window of the PWM bank: byte offset, write data/strobe and
// combinational read data.
interface pwm_bank_if #(
    parameter int ADDR_W = 6
);
    // WE qualifies a single-cycle write at A; there is no back-pressure, and
    // RD follows A combinationally with no read strobe.
    logic [ADDR_W-1:0] A;
    logic [31:0]       WD;
    logic              WE;
    logic [31:0]       RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);

endinterface

// File: rtl/pwm_bank_channel.sv
// One PWM channel: shadow/active duty pair and the registered compare output.
module pwm_bank_channel #(
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [RES_W-1:0] wd,
    input  logic             load,
    input  logic             en,
    input  logic [RES_W-1:0] cnt,
    output logic [RES_W-1:0] duty_rd,
    output logic             pwm
);

    logic [RES_W-1:0] duty_sh;
    logic [RES_W-1:0] duty_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr) begin
                duty_sh <= wd;
            end
            // A write landing on the load edge reaches the active copy one
            // period later, so a period never sees a half-applied duty.
            if (load) begin
                duty_act <= duty_sh;
            end
            pwm <= en && (cnt < duty_act);
        end
    end

    assign duty_rd = duty_sh;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with prescaler, edge/center counting and period-boundary
// double buffering of PERIOD and DUTY; one register window on the bus.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int RES_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    pwm_bank_if.slave       bus,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_tick
);

    logic             en_q;
    logic             mode_q;
    logic             pflag_q;
    logic [15:0]      prescale_q;
    logic [RES_W-1:0] period_sh;
    logic [RES_W-1:0] period_act;

    logic [15:0]      pcnt_q, pcnt_d;
    logic [RES_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic             step;
    logic             boundary;
    logic             bnd_q;
    logic             load;

    logic                       sel_ctrl, sel_pre, sel_per;
    logic [N_CH-1:0]            sel_duty;
    logic                       wr_ctrl, wr_pre, wr_per;
    logic [RES_W-1:0]           wd_res;
    logic [N_CH-1:0][RES_W-1:0] duty_rd;
    logic [31:0]                rd;
    logic                       unused_wd;

    assign sel_ctrl = (bus.A == ADDR_W'(OFF_CTRL));
    assign sel_pre  = (bus.A == ADDR_W'(OFF_PRESCALE));
    assign sel_per  = (bus.A == ADDR_W'(OFF_PERIOD));
    assign wr_ctrl  = bus.WE && sel_ctrl;
    assign wr_pre   = bus.WE && sel_pre;
    assign wr_per   = bus.WE && sel_per;
    assign wd_res   = bus.WD[RES_W-1:0];
    assign unused_wd = ^bus.WD;

    // Counter next state; the prescaler and counter only move while enabled.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        step   = 1'b0;
        if (!en_q) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
        end else begin
            // >= keeps the prescaler from wrapping through 65535 if PRESCALE
            // is lowered below the running count.
            step   = (pcnt_q >= prescale_q);
            pcnt_d = step ? 16'd0 : pcnt_q + 16'd1;
            if (step) begin
                if (period_act == '0) begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                end else begin
                    case (mode_q)
                        MODE_EDGE: begin
                            dir_d = DIR_UP;
                            cnt_d = (cnt_q >= period_act) ? '0 : cnt_q + RES_W'(1);
                        end
                        MODE_CENTER: begin
                            if (dir_q == DIR_UP && cnt_q < period_act) begin
                                cnt_d = cnt_q + RES_W'(1);
                            end else begin
                                dir_d = DIR_DOWN;
                                cnt_d = (cnt_q == '0) ? '0 : cnt_q - RES_W'(1);
                            end
                            if (cnt_d == '0) begin
                                dir_d = DIR_UP;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign boundary = step && (cnt_d == '0);
    assign load     = boundary || !en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            mode_q      <= MODE_EDGE;
            pflag_q     <= 1'b0;
            prescale_q  <= '0;
            period_sh   <= '0;
            period_act  <= '0;
            pcnt_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            bnd_q       <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q   <= bus.WD[CTRL_EN_BIT];
                mode_q <= bus.WD[CTRL_MODE_BIT];
            end
            if (boundary) begin
                pflag_q <= 1'b1;
            end else if (wr_ctrl && bus.WD[CTRL_PFLAG_BIT]) begin
                pflag_q <= 1'b0;
            end
            if (wr_pre) begin
                prescale_q <= bus.WD[15:0];
            end
            if (wr_per) begin
                period_sh <= wd_res;
            end
            if (load) begin
                period_act <= period_sh;
            end
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            // Delayed one clk so the tick lines up with the cnt=0 output.
            bnd_q       <= boundary;
            period_tick <= bnd_q && en_q;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign sel_duty[i] = (bus.A == ADDR_W'(duty_off(i)));

        pwm_bank_channel #(
            .RES_W (RES_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr      (bus.WE && sel_duty[i]),
            .wd      (wd_res),
            .load    (load),
            .en      (en_q),
            .cnt     (cnt_q),
            .duty_rd (duty_rd[i]),
            .pwm     (pwm_out[i])
        );
    end

    always_comb begin
        rd = '0;
        if (sel_ctrl) begin
            rd[CTRL_EN_BIT]    = en_q;
            rd[CTRL_MODE_BIT]  = mode_q;
            rd[CTRL_PFLAG_BIT] = pflag_q;
        end
        if (sel_pre) begin
            rd[15:0] = prescale_q;
        end
        if (sel_per) begin
            rd[RES_W-1:0] = period_sh;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (sel_duty[i]) begin
                rd[RES_W-1:0] = duty_rd[i];
            end
        end
    end

    assign bus.RD = rd;

endmodule
